// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared encodings for the burst memory master. Covers the
//                access-size codes, the read/write encoding, the default
//                memory window, the FSM state type and the size-to-beat
//                helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

  // access_size encodings, one per burst length
  localparam logic [1:0] SIZE_1W  = 2'b00;
  localparam logic [1:0] SIZE_4W  = 2'b01;
  localparam logic [1:0] SIZE_8W  = 2'b10;
  localparam logic [1:0] SIZE_16W = 2'b11;

  // memory rw encoding
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // default memory window
  localparam logic [31:0] MEM_START_ADDR = 32'h8002_0000;
  localparam int unsigned MEM_DEPTH      = 1048576;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Index of the final beat (N-1) for an access-size code
  function automatic logic [3:0] size_to_last(input logic [1:0] size);
    logic [3:0] last;
    case (size)
      SIZE_1W:  last = 4'd0;
      SIZE_4W:  last = 4'd3;
      SIZE_8W:  last = 4'd7;
      default:  last = 4'd15;
    endcase
    return last;
  endfunction

  // Beat count N for an access-size code
  function automatic logic [4:0] size_to_beats(input logic [1:0] size);
    return {1'b0, size_to_last(size)} + 5'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mem_addr_gen
//  Description : Beat address register and beat counter. Load captures the
//                start address and the final beat index. Advance steps the
//                address by one word and bumps the counter. last_o flags the
//                final beat of the burst.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_addr_gen
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [3:0]            load_last_i,
  input  logic                  advance_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            count_q, count_d;
  logic [3:0]            last_idx_q, last_idx_d;

  // Next address/count: load wins over advance, otherwise hold
  always_comb begin
    addr_d     = addr_q;
    count_d    = count_q;
    last_idx_d = last_idx_q;
    if (load_i) begin
      addr_d     = load_addr_i;
      count_d    = 4'd0;
      last_idx_d = load_last_i;
    end else if (advance_i) begin
      addr_d  = addr_q + ADDR_WIDTH'(4);
      count_d = count_q + 4'd1;
    end
  end

  // Address and counter registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      addr_q     <= '0;
      count_q    <= 4'd0;
      last_idx_q <= 4'd0;
    end else begin
      addr_q     <= addr_d;
      count_q    <= count_d;
      last_idx_q <= last_idx_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (count_q == last_idx_q);

endmodule
`default_nettype wire

// File: rtl/mem_burst_master.sv
`default_nettype none
// ============================================================================
//  Module      : mem_burst_master
//  Description : Burst initiator for the big-endian byte-addressed memory
//                port. Takes one 1/4/8/16-word request at a time, streams
//                write words to memory and read words back to the requester.
//                Define ADDR_CHECK_EN to reject misaligned or out-of-window
//                requests with an err pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] START_ADDR = MEM_START_ADDR,
  parameter int unsigned DEPTH      = MEM_DEPTH
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_rw_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_in_o,
  output logic [1:0]            mem_access_size_o,
  output logic                  mem_rw_o,
  output logic                  mem_enable_o,
  input  logic                  mem_busy_i,
  input  logic [DATA_WIDTH-1:0] mem_data_out_i
);

  state_e     state_q, state_d;
  logic [1:0] size_q, size_d;
  logic       rw_q, rw_d;
  logic       rd_valid_q, rd_valid_d;
  logic       rd_last_q, rd_last_d;
  logic       err_d;
  logic       load;
  logic       advance;
  logic       last_beat;
  logic       reject;

  mem_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .load_i      (load),
    .load_addr_i (req_addr_i),
    .load_last_i (size_to_last(req_size_i)),
    .advance_i   (advance),
    .addr_o      (mem_address_o),
    .last_o      (last_beat)
  );

`ifdef ADDR_CHECK_EN
  logic [ADDR_WIDTH:0] req_end;
  logic [ADDR_WIDTH:0] win_end;
  logic                err_q;

  // Burst end and window end carry one extra bit so a wrap is caught
  assign req_end = {1'b0, req_addr_i} + (ADDR_WIDTH+1)'({size_to_beats(req_size_i), 2'b00});
  assign win_end = (ADDR_WIDTH+1)'(START_ADDR) + (ADDR_WIDTH+1)'(DEPTH);
  assign reject  = (req_addr_i[1:0] != 2'b00) ||
                   (req_addr_i < ADDR_WIDTH'(START_ADDR)) ||
                   (req_end > win_end);

  // Rejection pulse lands the cycle after the offending request
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_cfg;

  assign reject     = 1'b0;
  assign err_o      = 1'b0;
  assign unused_cfg = ^{START_ADDR, DEPTH, err_d};
`endif

  // Next-state and handshake decode; every output defaults inactive
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    rw_d         = rw_q;
    rd_valid_d   = 1'b0;
    rd_last_d    = 1'b0;
    err_d        = 1'b0;
    load         = 1'b0;
    advance      = 1'b0;
    req_ready_o  = 1'b0;
    wr_ready_o   = 1'b0;
    mem_enable_o = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            load    = 1'b1;
            size_d  = req_size_i;
            rw_d    = req_rw_i;
            state_d = (req_rw_i == RW_READ) ? ST_READ : ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        wr_ready_o   = ~mem_busy_i;
        mem_enable_o = wr_valid_i;
        if (wr_valid_i && !mem_busy_i) begin
          advance = 1'b1;
          if (last_beat) state_d = ST_DONE;
        end
      end
      ST_READ: begin
        mem_enable_o = 1'b1;
        if (!mem_busy_i) begin
          advance    = 1'b1;
          rd_valid_d = 1'b1;
          rd_last_d  = last_beat;
          if (last_beat) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched request attributes and the one-cycle read-valid lag
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      size_q     <= 2'b00;
      rw_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      rw_q       <= rw_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Memory returns read data one cycle after the beat, aligned with rd_valid
  assign rd_valid_o        = rd_valid_q;
  assign rd_last_o         = rd_last_q;
  assign rd_data_o         = rd_valid_q ? mem_data_out_i : '0;
  assign mem_data_in_o     = (state_q == ST_WRITE) ? wr_data_i : '0;
  assign mem_access_size_o = size_q;
  assign mem_rw_o          = rw_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_burst_master
//  Description : Directed self-checking bench for mem_burst_master.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_rw;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        done;
  logic        err;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_access_size;
  logic        mem_rw;
  logic        mem_enable;
  logic        mem_busy;
  logic [31:0] mem_data_out;

  int checks = 0;
  int errors = 0;

  mem_burst_master dut (
    .clock_i           (clk),
    .reset_i           (rst),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_addr_i        (req_addr),
    .req_size_i        (req_size),
    .req_rw_i          (req_rw),
    .wr_valid_i        (wr_valid),
    .wr_ready_o        (wr_ready),
    .wr_data_i         (wr_data),
    .rd_valid_o        (rd_valid),
    .rd_data_o         (rd_data),
    .rd_last_o         (rd_last),
    .done_o            (done),
    .err_o             (err),
    .mem_address_o     (mem_address),
    .mem_data_in_o     (mem_data_in),
    .mem_access_size_o (mem_access_size),
    .mem_rw_o          (mem_rw),
    .mem_enable_o      (mem_enable),
    .mem_busy_i        (mem_busy),
    .mem_data_out_i    (mem_data_out)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  int b;

  initial begin
    rst = 1'b1; req_valid = 0; req_addr = 0; req_size = 0; req_rw = 0;
    wr_valid = 0; wr_data = 0; mem_busy = 0; mem_data_out = 0;

    // ---------------- reset state
    cyc(); cyc();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_enable", mem_enable, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    rst = 1'b0;
    cyc();

    // ---------------- 1-word write
    req_valid = 1; req_addr = 32'h8002_0000; req_size = 2'b00; req_rw = 0;
    wr_valid = 1; wr_data = 32'hDEAD_BEEF;
    #1 chk("w1_req_ready", req_ready, 1);
    cyc();
    req_valid = 0;
    #1;
    chk("w1_enable", mem_enable, 1);
    chk("w1_addr", mem_address, 32'h8002_0000);
    chk("w1_data", mem_data_in, 32'hDEAD_BEEF);
    chk("w1_rw", mem_rw, 0);
    chk("w1_req_ready_busy", req_ready, 0);
    chk("w1_done_early", done, 0);
    cyc();
    wr_valid = 0;
    #1;
    chk("w1_done", done, 1);
    chk("w1_enable_off", mem_enable, 0);
    cyc();
    #1;
    chk("w1_idle_ready", req_ready, 1);
    chk("w1_done_off", done, 0);

    // ---------------- 4-word read, memory answers one cycle after each beat
    req_valid = 1; req_addr = 32'h8002_0010; req_size = 2'b01; req_rw = 1;
    cyc();
    req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      mem_data_out = (i > 0) ? 32'hC0DE_0000 + i - 1 : 32'h0;
      #1;
      chk("r4_enable", mem_enable, 1);
      chk("r4_addr", mem_address, 32'h8002_0010 + 4 * i);
      chk("r4_size", mem_access_size, 2'b01);
      chk("r4_rw", mem_rw, 1);
      chk("r4_rd_valid", rd_valid, (i > 0) ? 1 : 0);
      chk("r4_rd_last", rd_last, 0);
      if (i > 0) chk("r4_rd_data", rd_data, 32'hC0DE_0000 + i - 1);
      cyc();
    end
    mem_data_out = 32'hC0DE_0003;
    #1;
    chk("r4_drain_valid", rd_valid, 1);
    chk("r4_drain_last", rd_last, 1);
    chk("r4_drain_data", rd_data, 32'hC0DE_0003);
    chk("r4_drain_enable", mem_enable, 0);
    chk("r4_drain_done", done, 0);
    cyc();
    #1;
    chk("r4_done", done, 1);
    chk("r4_done_rd_valid", rd_valid, 0);
    cyc();

    // ---------------- 8-word write, memory stalls two cycles at beat 3
    req_valid = 1; req_addr = 32'h8002_0000; req_size = 2'b10; req_rw = 0;
    #1 chk("w8_req_ready", req_ready, 1);
    cyc();
    req_valid = 0;
    for (int c = 0; c < 10; c++) begin
      b = (c < 3) ? c : ((c < 5) ? 3 : c - 2);
      mem_busy = (c == 3 || c == 4);
      wr_valid = 1;
      wr_data  = 32'h1111_0000 + b;
      #1;
      chk("w8_addr", mem_address, 32'h8002_0000 + 4 * b);
      chk("w8_wr_ready", wr_ready, (c == 3 || c == 4) ? 0 : 1);
      chk("w8_enable", mem_enable, 1);
      chk("w8_data", mem_data_in, 32'h1111_0000 + b);
      chk("w8_done_early", done, 0);
      cyc();
    end
    wr_valid = 0; mem_busy = 0;
    #1;
    chk("w8_done", done, 1);
    chk("w8_wr_ready_off", wr_ready, 0);
    cyc();

    // ---------------- 4-word write with a one-cycle wr_valid bubble
    req_valid = 1; req_addr = 32'h8002_0040; req_size = 2'b01; req_rw = 0;
    cyc();
    req_valid = 0;
    for (int c = 0; c < 5; c++) begin
      b = (c <= 2) ? c : c - 1;
      wr_valid = (c != 2);
      wr_data  = 32'h4444_0000 + b;
      #1;
      chk("w4b_enable", mem_enable, (c != 2) ? 1 : 0);
      chk("w4b_addr", mem_address, 32'h8002_0040 + 4 * b);
      chk("w4b_done_early", done, 0);
      cyc();
    end
    wr_valid = 0;
    #1 chk("w4b_done", done, 1);
    cyc();

    // ---------------- 16-word read, reset asserted at beat 7
    req_valid = 1; req_addr = 32'h8002_0100; req_size = 2'b11; req_rw = 1;
    cyc();
    req_valid = 0;
    for (int i = 0; i < 8; i++) begin
      mem_data_out = 32'h5555_0000 + i;
      #1;
      chk("r16_addr", mem_address, 32'h8002_0100 + 4 * i);
      chk("r16_size", mem_access_size, 2'b11);
      if (i < 7) cyc();
    end
    rst = 1'b1;
    #1;
    chk("r16rst_enable", mem_enable, 0);
    chk("r16rst_addr", mem_address, 0);
    chk("r16rst_rd_valid", rd_valid, 0);
    chk("r16rst_rd_data", rd_data, 0);
    chk("r16rst_rd_last", rd_last, 0);
    chk("r16rst_rw", mem_rw, 0);
    chk("r16rst_size", mem_access_size, 0);
    chk("r16rst_done", done, 0);
    chk("r16rst_req_ready", req_ready, 1);
    cyc();
    chk("r16rst_done_hold", done, 0);
    rst = 1'b0;
    mem_data_out = 0;
    cyc();
    #1 chk("r16rst_after_done", done, 0);

    // ---------------- fresh 1-word read after the reset
    req_valid = 1; req_addr = 32'h8002_0200; req_size = 2'b00; req_rw = 1;
    #1 chk("r1_req_ready", req_ready, 1);
    cyc();
    req_valid = 0;
    #1;
    chk("r1_enable", mem_enable, 1);
    chk("r1_addr", mem_address, 32'h8002_0200);
    chk("r1_rd_valid_early", rd_valid, 0);
    cyc();
    mem_data_out = 32'hFEED_F00D;
    #1;
    chk("r1_rd_valid", rd_valid, 1);
    chk("r1_rd_last", rd_last, 1);
    chk("r1_rd_data", rd_data, 32'hFEED_F00D);
    chk("r1_done_early", done, 0);
    cyc();
    #1 chk("r1_done", done, 1);
    cyc();

    // ---------------- misaligned request
    req_valid = 1; req_addr = 32'h8002_0002; req_size = 2'b00; req_rw = 0;
    wr_valid = 1; wr_data = 32'h0BAD_0BAD;
    #1 chk("mis_req_ready", req_ready, 1);
    cyc();
    req_valid = 0;
`ifdef ADDR_CHECK_EN
    #1;
    chk("mis_err", err, 1);
    chk("mis_enable", mem_enable, 0);
    chk("mis_req_ready_after", req_ready, 1);
    cyc();
    #1;
    chk("mis_err_off", err, 0);
    chk("mis_enable_off", mem_enable, 0);
    chk("mis_done", done, 0);
`else
    #1;
    chk("mis_err_tied", err, 0);
    chk("mis_accept_enable", mem_enable, 1);
    chk("mis_accept_addr", mem_address, 32'h8002_0002);
    cyc();
    wr_valid = 0;
    #1;
    chk("mis_done", done, 1);
    chk("mis_err_tied2", err, 0);
`endif
    wr_valid = 0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
